// File: rtl/fa_pipe_adder.sv
// rtl/fa_pipe_adder.sv - pipelined WIDTH-bit add/subtract, one CHUNK-bit ripple slice per stage
// Global stall: every register, valid bits included, holds while the output is blocked.
module fa_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  // Per-stage skew registers: operands still to be added and result slices already done.
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  b_q  [STAGES];
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ovf_q;

  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [WIDTH-1:0]  s_nx [STAGES];
  logic [CHUNK:0]    part [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] c_nx;
  logic [STAGES-1:0] v_in;
  logic              ovf_nx;
  logic              stall;

  assign stall     = v_q[LAST] & ~out_ready;
  assign in_ready  = ~stall & ~rst;
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign carry     = c_q[LAST];
  assign overflow  = ovf_q;

  always_comb begin
    // Subtract is A + ~B + ~cin, so borrow-in inverts along with B.
    a_in[0] = a;
    b_in[0] = sub ? ~b : b;
    c_in[0] = sub ^ cin;
    s_in[0] = '0;
    v_in[0] = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      a_in[i] = a_q[i-1];
      b_in[i] = b_q[i-1];
      c_in[i] = c_q[i-1];
      s_in[i] = s_q[i-1];
      v_in[i] = v_q[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      part[i] = {1'b0, a_in[i][i*CHUNK +: CHUNK]} + {1'b0, b_in[i][i*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, c_in[i]};
      s_nx[i] = s_in[i];
      s_nx[i][i*CHUNK +: CHUNK] = part[i][CHUNK-1:0];
      c_nx[i] = part[i][CHUNK];
    end
    // Carry into the MSB is recovered as a^b^sum at that bit, then compared with carry out.
    ovf_nx = (a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ s_nx[LAST][WIDTH-1]) ^ c_nx[LAST];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        s_q[i] <= '0;
      end
    end else if (!stall) begin
      v_q   <= v_in;
      c_q   <= c_nx;
      ovf_q <= ovf_nx;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= a_in[i];
        b_q[i] <= b_in[i];
        s_q[i] <= s_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_fa_pipe_adder.sv
// tb/tb_fa_pipe_adder.sv - scoreboard bench for fa_pipe_adder, main 16/4 instance plus width/chunk sweep
module tb_fa_pipe_adder;

  typedef struct {
    logic [63:0] sum;
    logic        carry;
    logic        ovf;
    int          acc;
    bit          lat;
  } exp_t;

  localparam int MW = 16;
  localparam int MC = 4;
  localparam int MS = MW / MC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent arithmetic model: wide integer add/sub, signed range test for overflow.
  function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv,
                                 input logic ci, input logic sb, input int w);
    longint ua, ub, sa, sbv, full, r, mask, half, c;
    exp_t e;
    mask = (longint'(1) <<< w) - 1;
    half = longint'(1) <<< (w - 1);
    ua   = longint'(av) & mask;
    ub   = longint'(bv) & mask;
    c    = ci ? 1 : 0;
    sa   = (ua >= half) ? ua - (half <<< 1) : ua;
    sbv  = (ub >= half) ? ub - (half <<< 1) : ub;
    if (sb) begin
      full    = ua - ub - c;
      r       = sa - sbv - c;
      e.carry = (full >= 0);
    end else begin
      full    = ua + ub + c;
      r       = sa + sbv + c;
      e.carry = (full >= (half <<< 1));
    end
    e.sum = 64'(full & mask);
    e.ovf = (r >= half) || (r < -half);
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Main instance
  logic          rst, in_valid, in_ready, cin, sub, out_valid, out_ready, carry, overflow;
  logic [MW-1:0] a, b, sum;

  fa_pipe_adder #(.WIDTH(MW), .CHUNK(MC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow)
  );

  exp_t          q[$];
  int            cyc = 0;
  int            stall_req = 0;
  int            first_acc = 0;
  int            last_con = 0;
  bit            push_en = 1'b1;
  bit            lat_en = 1'b0;
  bit            dir_en = 1'b0;
  bit            last_acc = 1'b0;
  bit            stalling = 1'b0;
  bit            snap_ok = 1'b0;
  logic [MW+1:0] snap;
  logic [MW-1:0] dir_sum;
  logic          dir_c, dir_o;

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (stall_req > 0 && out_valid) begin
      out_ready = 1'b0;
      stalling  = 1'b1;
    end else begin
      out_ready = 1'b1;
      stalling  = 1'b0;
    end
    #1;
    check("in_ready", in_ready, (rst || stalling) ? 1'b0 : 1'b1);
    if (stalling) begin
      if (snap_ok) check("frozen", {sum, carry, overflow}, snap);
      snap      = {sum, carry, overflow};
      snap_ok   = 1'b1;
      stall_req = stall_req - 1;
    end else begin
      snap_ok = 1'b0;
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        e = q.pop_front();
        check("sum", sum, e.sum);
        check("carry", carry, e.carry);
        check("overflow", overflow, e.ovf);
        if (e.lat) check("latency", cyc + 1 - e.acc, MS);
        last_con = cyc + 1;
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc && push_en) begin
      if (dir_en) begin
        e.sum = 64'(dir_sum); e.carry = dir_c; e.ovf = dir_o;
      end else begin
        e = model(64'(a), 64'(b), cin, sub, MW);
      end
      e.acc = cyc + 1;
      e.lat = lat_en;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [MW-1:0] av, input logic [MW-1:0] bv,
                      input logic ci, input logic sb);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (last_acc) break;
    end
    check("accept", last_acc, 1'b1);
  endtask

  task automatic send_dir(input logic [MW-1:0] av, input logic [MW-1:0] bv, input logic ci,
                          input logic sb, input logic [MW-1:0] es, input logic ec, input logic eo);
    dir_en = 1'b1; dir_sum = es; dir_c = ec; dir_o = eo;
    send(av, bv, ci, sb);
    dir_en = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 60 && q.size() > 0; t++) tick();
    check("drain_empty", q.size(), 0);
  endtask

  // Sweep instances: random traffic with bubbles, out_ready held high, latency = WIDTH/CHUNK.
  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int W = (g == 2) ? 32 : 16;
    localparam int C = (g == 0) ? 16 : ((g == 1) ? 1 : 8);
    localparam int S = W / C;
    logic         rst_s, iv, ir, cin_s, sub_s, ov, co, of;
    logic         or_s = 1'b1;
    logic [W-1:0] a_s, b_s, s_s;
    exp_t         sq[$];
    bit           done = 1'b0;

    fa_pipe_adder #(.WIDTH(W), .CHUNK(C)) u (
      .clk(clk), .rst(rst_s), .in_valid(iv), .in_ready(ir),
      .a(a_s), .b(b_s), .cin(cin_s), .sub(sub_s),
      .out_valid(ov), .out_ready(or_s),
      .sum(s_s), .carry(co), .overflow(of)
    );

    initial begin
      exp_t e;
      int   got, sent, ecyc;
      got = 0; sent = 0; ecyc = 0;
      rst_s = 1'b1; iv = 1'b0; a_s = '0; b_s = '0; cin_s = 1'b0; sub_s = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_s = 1'b0;
      for (int t = 0; t < 400 && got < 20; t++) begin
        @(negedge clk);
        if (ov) begin
          if (sq.size() == 0) begin
            check($sformatf("sw%0d_spurious", g), ov, 1'b0);
          end else begin
            e = sq.pop_front();
            check($sformatf("sw%0d_sum", g), 64'(s_s), e.sum);
            check($sformatf("sw%0d_carry", g), co, e.carry);
            check($sformatf("sw%0d_ovf", g), of, e.ovf);
            check($sformatf("sw%0d_latency", g), ecyc + 1 - e.acc, S);
            got++;
          end
        end
        if (iv && ir) begin
          e = model(64'(a_s), 64'(b_s), cin_s, sub_s, W);
          e.acc = ecyc + 1;
          sq.push_back(e);
          sent++;
        end
        @(posedge clk);
        ecyc++;
        #1;
        if (sent < 20 && $urandom_range(0, 3) != 0) begin
          iv = 1'b1; a_s = W'($urandom); b_s = W'($urandom);
          cin_s = 1'($urandom); sub_s = 1'($urandom);
        end else begin
          iv = 1'b0;
        end
      end
      check($sformatf("sw%0d_count", g), got, 20);
      done = 1'b1;
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;

    // Reset with in_valid held high: nothing accepted, outputs cleared
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_carry", carry, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    repeat (6) tick();

    // Directed vectors, back-to-back, latency checked
    lat_en = 1'b1;
    send_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_dir(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    send_dir(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    drain();

    // Backpressure: 8 random transactions, 3-cycle output stall
    lat_en = 1'b0;
    stall_req = 3;
    for (int i = 0; i < 8; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      if (i == 0) first_acc = cyc;
    end
    drain();
    check("stall_cycles_used", stall_req, 0);
    check("bp_total_time", last_con - first_acc, 8 + 4 + 3 - 1);

    // Mid-flight reset: 3 in flight are discarded
    push_en = 1'b0;
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 1'b0);
    push_en = 1'b1;
    repeat (8) tick();
    lat_en = 1'b1;
    send(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
    drain();

    for (int t = 0; t < 3000 && !(sw[0].done && sw[1].done && sw[2].done); t++) @(posedge clk);
    check("sweep_done", {sw[0].done, sw[1].done, sw[2].done}, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
